muldiv_sequencer: RTL and testbench

//  Sequences the shared multi-cycle multiplier and divider units behind the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_sequencer_if.sv | 39 +++
 rtl/muldiv_cycle_counter.sv | 36 +++
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide sequencer, the control unit and
//   the HI/LO source muxes:
//     seqState_t  - sequencer states (IDLE, RUN, WB, ZERO)
//     OP_*        - request operation encoding on req_op
//     SEL_*       - HI/LO source mux select encoding
//     maxOf / counterWidth - sizing helpers for the cycle counter
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2,
    ST_ZERO = 2'd3
  } seqState_t;

  localparam logic OP_MULT  = 1'b0;
  localparam logic OP_DIV   = 1'b1;

  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit above the log2 so a load of the largest cycle count fits
  // even when that count is an exact power of two.
  function automatic int counterWidth(input int multCycles, input int divCycles);
    return $clog2(maxOf(multCycles, divCycles)) + 1;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Request/response bundle between the control unit (master) and the
//   mult/div sequencer (slave).
//   master drives : req_valid, req_op, divisor, abort
//   slave drives  : req_ready, mult_start, div_start, hi_sel, lo_sel,
//                   hi_write, lo_write, busy, done, div_zero
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_op;
  logic [WIDTH-1:0] divisor;
  logic             abort;

  logic             req_ready;
  logic             mult_start;
  logic             div_start;
  logic             hi_sel;
  logic             lo_sel;
  logic             hi_write;
  logic             lo_write;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output req_valid, req_op, divisor, abort,
    input  req_ready, mult_start, div_start, hi_sel, lo_sel,
           hi_write, lo_write, busy, done, div_zero
  );

  modport slave (
    input  req_valid, req_op, divisor, abort,
    output req_ready, mult_start, div_start, hi_sel, lo_sel,
           hi_write, lo_write, busy, done, div_zero
  );

endinterface

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter
//   Down-counter timing a multi-cycle mult/div operation.
//   clk, reset : clock and synchronous active-low reset
//   load       : load loadValue (has priority over dec)
//   loadValue  : cycles remaining minus one
//   dec        : decrement by one; saturates at zero, never wraps
//   zero       : counter currently holds zero
module muldiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load first, otherwise saturating decrement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= loadValue;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequences the shared multi-cycle multiplier and divider behind HI/LO.
//   Accepts one request at a time, pulses the selected unit's start, times the
//   operation, then writes HI/LO for one cycle. A divide with a zero divisor
//   raises div_zero instead of running the divider.
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : muldiv_sequencer_if.slave (request, abort, starts, selects,
//           HI/LO write enables, busy/done/div_zero status)
//   All outputs are registered: they are decoded from the next state so they
//   line up with the state they describe.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int               CNT_W        = counterWidth(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD    = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD     = CNT_W'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] ZERO_DIVISOR = {WIDTH{1'b0}};

  seqState_t        state_r;
  seqState_t        nextState_s;
  logic             opQ_r;

  logic             accept_s;
  logic             cntLoad_s;
  logic [CNT_W-1:0] cntLoadValue_s;
  logic             cntDec_s;
  logic             cntZero_s;
  logic             startMult_s;
  logic             startDiv_s;

  logic             ready_r;
  logic             multStart_r;
  logic             divStart_r;
  logic             write_r;
  logic             busy_r;
  logic             divZero_r;

  muldiv_cycle_counter #(
    .CNT_W (CNT_W)
  ) uCounter (
    .clk       (clk),
    .reset     (reset),
    .load      (cntLoad_s),
    .loadValue (cntLoadValue_s),
    .dec       (cntDec_s),
    .zero      (cntZero_s)
  );

  // Next-state, counter control and start-pulse decode.
  always_comb begin
    nextState_s    = state_r;
    accept_s       = 1'b0;
    cntLoad_s      = 1'b0;
    cntLoadValue_s = MULT_LOAD;
    cntDec_s       = 1'b0;
    startMult_s    = 1'b0;
    startDiv_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // abort beats a simultaneous request
        if (bus.req_valid && !bus.abort) begin
          accept_s = 1'b1;
          if ((bus.req_op == OP_DIV) && (bus.divisor == ZERO_DIVISOR)) begin
            nextState_s = ST_ZERO;
          end else begin
            nextState_s = ST_RUN;
            cntLoad_s   = 1'b1;
            if (bus.req_op == OP_DIV) begin
              cntLoadValue_s = DIV_LOAD;
              startDiv_s     = 1'b1;
            end else begin
              cntLoadValue_s = MULT_LOAD;
              startMult_s    = 1'b1;
            end
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          nextState_s = ST_IDLE;
        end else if (cntZero_s) begin
          nextState_s = ST_WB;
        end else begin
          nextState_s = ST_RUN;
          cntDec_s    = 1'b1;
        end
      end
      // WB and ZERO always complete; abort is ignored there
      ST_WB:   nextState_s = ST_IDLE;
      ST_ZERO: nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Latched operation; also drives the HI/LO mux selects until the next accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      opQ_r <= OP_MULT;
    end else if (accept_s) begin
      opQ_r <= bus.req_op;
    end else begin
      opQ_r <= opQ_r;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_r     <= 1'b1;
      multStart_r <= 1'b0;
      divStart_r  <= 1'b0;
      write_r     <= 1'b0;
      busy_r      <= 1'b0;
      divZero_r   <= 1'b0;
    end else begin
      ready_r     <= (nextState_s == ST_IDLE);
      multStart_r <= startMult_s;
      divStart_r  <= startDiv_s;
      write_r     <= (nextState_s == ST_WB);
      busy_r      <= (nextState_s == ST_RUN) || (nextState_s == ST_WB);
      divZero_r   <= (nextState_s == ST_ZERO);
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.mult_start = multStart_r;
  assign bus.div_start  = divStart_r;
  assign bus.hi_sel     = (opQ_r == OP_DIV) ? SEL_DIV : SEL_MULT;
  assign bus.lo_sel     = (opQ_r == OP_DIV) ? SEL_DIV : SEL_MULT;
  assign bus.hi_write   = write_r;
  assign bus.lo_write   = write_r;
  assign bus.busy       = busy_r;
  assign bus.done       = write_r;
  assign bus.div_zero   = divZero_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer. A schedule-based reference
//   model (accept cycle -> start/write/ready cycles) predicts every output on
//   every cycle; table vectors and short directed sequences check latencies.
module tb_muldiv_sequencer;

  localparam int W  = 32;
  localparam int MC = 32;
  localparam int DC = 20;

  logic clk;
  logic reset;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(
    .WIDTH       (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle numbers of the scheduled events.
  int   cyc;
  int   readyAt;
  int   startAt;
  int   wbAt;
  int   zeroAt;
  logic startOp;
  logic selExp;

  typedef struct {
    logic         op;
    logic [W-1:0] dv;
    int           abortOff;
    int           expMs;
    int           expDs;
    int           expDone;
    int           expDz;
    int           expReady;
    logic         expSel;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic checkOutputs();
    logic [9:0] got;
    logic [9:0] exp;
    logic       wb;
    logic       bsy;
    wb  = (cyc == wbAt);
    bsy = (startAt >= 0) && (cyc >= startAt) && (cyc < readyAt);
    exp = {cyc >= readyAt, (cyc == startAt) && !startOp, (cyc == startAt) && startOp,
           selExp, selExp, wb, wb, bsy, wb, cyc == zeroAt};
    got = {bus.req_ready, bus.mult_start, bus.div_start, bus.hi_sel, bus.lo_sel,
           bus.hi_write, bus.lo_write, bus.busy, bus.done, bus.div_zero};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs cycle %0d got %b want %b (rdy ms ds hs ls hw lw busy done dz)",
               cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic tick(input logic rv, input logic op, input logic [W-1:0] dv, input logic ab);
    int n;
    bus.req_valid = rv;
    bus.req_op    = op;
    bus.divisor   = dv;
    bus.abort     = ab;
    if (!reset) begin
      readyAt = cyc + 1; startAt = -1; wbAt = -1; zeroAt = -1; selExp = 1'b0;
    end else if (cyc >= readyAt) begin
      if (rv && !ab) begin
        selExp = op;
        if (op && (dv == '0)) begin
          zeroAt = cyc + 1; readyAt = cyc + 2; startAt = -1; wbAt = -1;
        end else begin
          n = op ? DC : MC;
          startAt = cyc + 1; startOp = op; wbAt = cyc + n + 1;
          readyAt = cyc + n + 2; zeroAt = -1;
        end
      end
    end else if (ab && (startAt >= 0) && (cyc >= startAt) && (cyc < wbAt)) begin
      readyAt = cyc + 1; wbAt = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutputs();
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 100; k++) begin
      if (bus.req_ready) return;
      tick(1'b0, 1'b0, '0, 1'b0);
    end
    check("waitIdle_timeout", 0, 1);
  endtask

  // Issue one request and measure event offsets from the accept cycle.
  task automatic runVector(input int idx);
    int t, off, ms, ds, dn, dz, rdy;
    logic sel;
    ms = -1; ds = -1; dn = -1; dz = -1; rdy = -1; sel = 1'bx;
    waitIdle();
    t = cyc;
    tick(1'b1, vecs[idx].op, vecs[idx].dv, 1'b0);
    for (int k = 0; k < 3 * MC; k++) begin
      off = cyc - t;
      if (bus.mult_start && ms < 0) ms = off;
      if (bus.div_start && ds < 0) ds = off;
      if (bus.done && dn < 0) dn = off;
      if (bus.div_zero && dz < 0) dz = off;
      if (bus.req_ready) begin
        rdy = off;
        sel = bus.hi_sel;
        break;
      end
      tick(1'b0, 1'b0, '0, off == vecs[idx].abortOff);
    end
    check($sformatf("vec%0d_mult_start", idx), ms, vecs[idx].expMs);
    check($sformatf("vec%0d_div_start", idx), ds, vecs[idx].expDs);
    check($sformatf("vec%0d_done", idx), dn, vecs[idx].expDone);
    check($sformatf("vec%0d_div_zero", idx), dz, vecs[idx].expDz);
    check($sformatf("vec%0d_ready", idx), rdy, vecs[idx].expReady);
    check($sformatf("vec%0d_sel", idx), int'(sel), int'(vecs[idx].expSel));
  endtask

  initial begin
    int first, second, doneSeen;

    //            op    divisor        abort  ms  ds  done    dz  ready   sel
    vecs[0] = '{1'b0, 32'd5,          -1,    1, -1, MC + 1, -1, MC + 2, 1'b0};
    vecs[1] = '{1'b1, 32'd7,          -1,   -1,  1, DC + 1, -1, DC + 2, 1'b1};
    vecs[2] = '{1'b1, 32'd0,          -1,   -1, -1, -1,      1, 2,      1'b1};
    vecs[3] = '{1'b0, 32'd9,           5,    1, -1, -1,     -1, 6,      1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  -1,   -1,  1, DC + 1, -1, DC + 2, 1'b1};
    vecs[5] = '{1'b0, 32'd0,          -1,    1, -1, MC + 1, -1, MC + 2, 1'b0};
    vecs[6] = '{1'b1, 32'd3,           1,   -1,  1, -1,     -1, 2,      1'b1};
    vecs[7] = '{1'b1, 32'd3,          DC,   -1,  1, -1,     -1, DC + 1, 1'b1};
    vecs[8] = '{1'b1, 32'd0,           1,   -1, -1, -1,      1, 2,      1'b1};
    vecs[9] = '{1'b0, 32'd1,      MC + 1,    1, -1, MC + 1, -1, MC + 2, 1'b0};

    // Reset held two cycles with a pending request.
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.divisor = 32'd5; bus.abort = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0; readyAt = 0; startAt = -1; wbAt = -1; zeroAt = -1; startOp = 1'b0; selExp = 1'b0;
    checkOutputs();
    tick(1'b1, 1'b0, 32'd5, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    check("reset_no_start", int'(bus.mult_start | bus.div_start), 0);

    for (int i = 0; i < 10; i++) runVector(i);

    // abort together with req_valid in IDLE: nothing accepted.
    waitIdle();
    tick(1'b1, 1'b1, 32'd7, 1'b1);
    check("abort_beats_req_ready", int'(bus.req_ready), 1);
    check("abort_beats_req_start", int'(bus.div_start), 0);

    // Back-to-back: req_valid held, second accept exactly MC+2 later.
    waitIdle();
    first = -1; second = -1;
    for (int k = 0; k < 4 * MC; k++) begin
      if (bus.req_ready) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (second >= 0) break;
      tick(1'b1, 1'b0, 32'd1, 1'b0);
    end
    check("back_to_back_gap", second - first, MC + 2);

    // Reset mid-operation: no write may follow.
    waitIdle();
    tick(1'b1, 1'b0, 32'd2, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < MC + 5; k++) begin
      tick(1'b0, 1'b0, '0, 1'b0);
      if (bus.done || bus.hi_write) doneSeen = 1;
    end
    check("reset_mid_op_no_write", doneSeen, 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic         rv, op, ab;
      logic [W-1:0] dv;
      rv = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 1) == 1;
      dv = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      ab = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 299) != 0);
      tick(rv, op, dv, ab);
    end
    reset = 1'b1;
    tick(1'b0, 1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
